// File: rtl/keypad_entry_if.sv
// Keypad entry bus: scanner inputs plus the decoded entry/event outputs.
// Ports: keydown/key from the scanner; entry_bcd/entry_count, key/commit/func/reject
//        pulses and their held codes/values toward the countdown core.
interface keypad_entry_if;
  logic        keydown;
  logic [3:0]  key;
  logic [15:0] entry_bcd;
  logic [2:0]  entry_count;
  logic        key_pulse;
  logic [3:0]  key_code;
  logic        commit_pulse;
  logic [15:0] commit_bcd;
  logic        func_pulse;
  logic [1:0]  func_code;
  logic        reject_pulse;

  // Scanner / consumer side.
  modport master (
    output keydown, key,
    input  entry_bcd, entry_count, key_pulse, key_code, commit_pulse,
           commit_bcd, func_pulse, func_code, reject_pulse
  );

  // keypad_entry side.
  modport slave (
    input  keydown, key,
    output entry_bcd, entry_count, key_pulse, key_code, commit_pulse,
           commit_bcd, func_pulse, func_code, reject_pulse
  );
endinterface

// File: rtl/keypad_entry.sv
// Purpose: debounce scanner keydown/key into single key events and build a 4-digit BCD MM:SS entry.
// Latency: events register DEBOUNCE_CYCLES+2 clk edges after keydown is first sampled high.
// Backpressure: none; every accepted press produces one action, and the outputs are pulses or held values.
// Ports: clk, rst (sync, active-high); kp.keydown/kp.key in; entry, pulse and code outputs on kp.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  keypad_entry_if.slave  kp
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, RELEASE} state_t;

  // Two-flop synchronizer; key rides along the same stages so key_s stays aligned with keydown_s.
  logic [1:0] kd_sync;
  logic [3:0] key_sync1, key_sync2;
  logic       keydown_s;
  logic [3:0] key_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      kd_sync   <= 2'b00;
      key_sync1 <= 4'h0;
      key_sync2 <= 4'h0;
    end else begin
      kd_sync   <= {kd_sync[0], kp.keydown};
      key_sync1 <= kp.key;
      key_sync2 <= key_sync1;
    end
  end

  assign keydown_s = kd_sync[1];
  assign key_s     = key_sync2;

  // Debounce FSM.
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!keydown_s) begin
          cnt_d = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = 8'd0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (keydown_s) begin
          cnt_d = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Accepted press is staged one cycle; the action stage then applies it to the entry buffer.
  logic       press_q;
  logic [3:0] press_code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      press_q      <= 1'b0;
      press_code_q <= 4'h0;
    end else begin
      press_q <= accept;
      if (accept) press_code_q <= key_s;
    end
  end

  // Digit value from row/col: rows 0..2 with cols 0..2 are 1..9, code 13 is 0.
  logic [1:0] row, col;
  logic [3:0] digit_val;

  always_comb begin
    row       = press_code_q[3:2];
    col       = press_code_q[1:0];
    digit_val = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    if (press_code_q == 4'd13) digit_val = 4'd0;
  end

  logic [15:0] entry_bcd_q, commit_bcd_q;
  logic [2:0]  entry_count_q;
  logic [3:0]  key_code_q;
  logic [1:0]  func_code_q;
  logic        key_pulse_q, commit_pulse_q, func_pulse_q, reject_pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_bcd_q    <= 16'h0000;
      entry_count_q  <= 3'd0;
      commit_bcd_q   <= 16'h0000;
      key_code_q     <= 4'h0;
      func_code_q    <= 2'd0;
      key_pulse_q    <= 1'b0;
      commit_pulse_q <= 1'b0;
      func_pulse_q   <= 1'b0;
      reject_pulse_q <= 1'b0;
    end else begin
      key_pulse_q    <= press_q;
      commit_pulse_q <= 1'b0;
      func_pulse_q   <= 1'b0;
      reject_pulse_q <= 1'b0;
      if (press_q) begin
        key_code_q <= press_code_q;
        case (press_code_q)
          4'd3: begin // A: clear
            entry_bcd_q   <= 16'h0000;
            entry_count_q <= 3'd0;
          end
          4'd7, 4'd11, 4'd15: begin // B/C/D map to 0/1/2 via the row index
            func_pulse_q <= 1'b1;
            func_code_q  <= press_code_q[3:2] - 2'd1;
          end
          4'd12: begin // '*': drop the most recently entered digit
            if (entry_count_q != 3'd0) begin
              entry_bcd_q   <= {4'h0, entry_bcd_q[15:4]};
              entry_count_q <= entry_count_q - 3'd1;
            end
          end
          4'd14: begin // '#': commit unless empty or tens-of-seconds digit is not a valid 0..5
            if (entry_count_q == 3'd0 || entry_bcd_q[7:4] > 4'd5) begin
              reject_pulse_q <= 1'b1;
            end else begin
              commit_pulse_q <= 1'b1;
              commit_bcd_q   <= entry_bcd_q;
              entry_bcd_q    <= 16'h0000;
              entry_count_q  <= 3'd0;
            end
          end
          default: begin // digit keys
            if (entry_count_q == 3'd4) begin
              reject_pulse_q <= 1'b1;
            end else begin
              entry_bcd_q   <= {entry_bcd_q[11:0], digit_val};
              entry_count_q <= entry_count_q + 3'd1;
            end
          end
        endcase
      end
    end
  end

  assign kp.entry_bcd    = entry_bcd_q;
  assign kp.entry_count  = entry_count_q;
  assign kp.key_pulse    = key_pulse_q;
  assign kp.key_code     = key_code_q;
  assign kp.commit_pulse = commit_pulse_q;
  assign kp.commit_bcd   = commit_bcd_q;
  assign kp.func_pulse   = func_pulse_q;
  assign kp.func_code    = func_code_q;
  assign kp.reject_pulse = reject_pulse_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry: randomized and directed key presses with bounce, a
// key-level reference model feeding an expected-event queue, and a monitor that
// pops and compares on every key_pulse.
module tb_keypad_entry;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_entry_if kp ();

  keypad_entry #(.DEBOUNCE_CYCLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  code;
    logic [15:0] bcd;
    logic [2:0]  cnt;
    logic        commit;
    logic [15:0] cbcd;
    logic        func;
    logic [1:0]  fcode;
    logic        reject;
  } exp_t;

  exp_t q[$];

  // Reference model: keypad as characters, entry as a list of typed digits.
  string       keymap = "123A456B789C*0#D";
  int          digs[$];
  logic [15:0] m_commit;
  logic [1:0]  m_fcode;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    digs.delete();
    m_commit = 16'h0;
    m_fcode  = 2'd0;
  endfunction

  function automatic logic [15:0] entry_value();
    logic [15:0] v;
    v = 16'h0;
    foreach (digs[i]) v = (v << 4) | 16'(digs[i]);
    return v;
  endfunction

  function automatic exp_t model(input logic [3:0] code);
    exp_t e;
    byte  ch;
    int   s10;
    e  = '{default: 0};
    ch = keymap[code];
    if (ch >= 8'h30 && ch <= 8'h39) begin
      if (digs.size() < 4) digs.push_back(int'(ch) - 48);
      else e.reject = 1'b1;
    end else if (ch == 8'h2A) begin        // '*'
      if (digs.size() > 0) void'(digs.pop_back());
    end else if (ch == 8'h41) begin        // 'A'
      digs.delete();
    end else if (ch == 8'h23) begin        // '#'
      s10 = (digs.size() >= 2) ? digs[digs.size() - 2] : 0;
      if (digs.size() == 0 || s10 > 5) e.reject = 1'b1;
      else begin
        e.commit = 1'b1;
        m_commit = entry_value();
        digs.delete();
      end
    end else begin                         // 'B','C','D'
      e.func  = 1'b1;
      m_fcode = 2'(ch - 8'h42);
    end
    e.code  = code;
    e.bcd   = entry_value();
    e.cnt   = 3'(digs.size());
    e.cbcd  = m_commit;
    e.fcode = m_fcode;
    return e;
  endfunction

  function automatic void expect_press(input logic [3:0] code, input int at_cyc);
    exp_t e;
    e     = model(code);
    e.cyc = at_cyc;
    q.push_back(e);
  endfunction

  // Random bounce pattern with no run of v longer than 2 cycles.
  function automatic logic [7:0] rand_pat(input logic v);
    logic [7:0] p;
    int run;
    p   = 8'($urandom);
    run = 0;
    for (int i = 0; i < 8; i++) begin
      if (p[i] == v) begin
        run++;
        if (run > 2) begin
          p[i] = ~v;
          run  = 0;
        end
      end else run = 0;
    end
    return p;
  endfunction

  // Drive bounce bits (LSB first) then hold high; the event is due 2+N edges after
  // the first sampling edge of the final high run.
  task automatic begin_press(input logic [3:0] code, input logic [7:0] pre, input int npre);
    logic prev;
    int   t0;
    prev = 1'b0;
    t0   = 0;
    @(negedge clk);
    kp.key = code;
    for (int i = 0; i < npre; i++) begin
      @(negedge clk);
      if (pre[i] && !prev) t0 = cyc + 1;
      kp.keydown = pre[i];
      prev       = pre[i];
    end
    @(negedge clk);
    if (!prev) t0 = cyc + 1;
    kp.keydown = 1'b1;
    expect_press(code, t0 + 2 + N);
  endtask

  task automatic hold_release(input int hold, input logic [7:0] rel, input int nrel);
    repeat (hold) @(negedge clk);
    for (int i = 0; i < nrel; i++) begin
      @(negedge clk);
      kp.keydown = rel[i];
    end
    @(negedge clk);
    kp.keydown = 1'b0;
    repeat (N + 4 + $urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code);
    begin_press(code, 8'h00, 0);
    hold_release(N + 2 + $urandom_range(0, 4), 8'h00, 0);
  endtask

  task automatic press_bouncy(input logic [3:0] code);
    begin_press(code, rand_pat(1'b1), $urandom_range(0, 6));
    hold_release(N + 2 + $urandom_range(0, 6), rand_pat(1'b0), $urandom_range(0, 6));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_entry_bcd"},    32'(kp.entry_bcd),    32'h0);
    chk({tag, "_entry_count"},  32'(kp.entry_count),  32'h0);
    chk({tag, "_key_pulse"},    32'(kp.key_pulse),    32'h0);
    chk({tag, "_key_code"},     32'(kp.key_code),     32'h0);
    chk({tag, "_commit_pulse"}, 32'(kp.commit_pulse), 32'h0);
    chk({tag, "_commit_bcd"},   32'(kp.commit_bcd),   32'h0);
    chk({tag, "_func_pulse"},   32'(kp.func_pulse),   32'h0);
    chk({tag, "_func_code"},    32'(kp.func_code),    32'h0);
    chk({tag, "_reject_pulse"}, 32'(kp.reject_pulse), 32'h0);
  endtask

  // Monitor: every key_pulse must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (kp.key_pulse) begin
        if (q.size() == 0) begin
          chk("unexpected_key_pulse", 32'(kp.key_pulse), 32'h0);
        end else begin
          e = q.pop_front();
          chk("pulse_cycle",  32'(cyc),             32'(e.cyc));
          chk("key_code",     32'(kp.key_code),     32'(e.code));
          chk("entry_bcd",    32'(kp.entry_bcd),    32'(e.bcd));
          chk("entry_count",  32'(kp.entry_count),  32'(e.cnt));
          chk("commit_pulse", 32'(kp.commit_pulse), 32'(e.commit));
          chk("commit_bcd",   32'(kp.commit_bcd),   32'(e.cbcd));
          chk("func_pulse",   32'(kp.func_pulse),   32'(e.func));
          chk("func_code",    32'(kp.func_code),    32'(e.fcode));
          chk("reject_pulse", 32'(kp.reject_pulse), 32'(e.reject));
        end
      end else if (kp.commit_pulse || kp.func_pulse || kp.reject_pulse) begin
        chk("event_without_key_pulse",
            32'({kp.commit_pulse, kp.func_pulse, kp.reject_pulse}), 32'h0);
      end
    end
  end

  initial begin
    int t0;
    logic [3:0] code;
    model_reset();

    // Reset with '0' already held: accepted once debounced after reset.
    rst        = 1'b1;
    kp.keydown = 1'b1;
    kp.key     = 4'd13;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    t0  = cyc + 1;
    expect_press(4'd13, t0 + 2 + N);
    hold_release(N + 3, 8'h00, 0);

    // Bounce: press 1,0,1,1,0 then high; release 0,1,0,0 then low. Key A clears.
    begin_press(4'd3, 8'b0000_1101, 5);
    hold_release(20, 8'b0000_0010, 4);

    // Entry and commit: 1,2,4,5,#.
    press(4'd0); press(4'd1); press(4'd4); press(4'd5); press(4'd14);

    // Overflow, backspace, clear.
    press(4'd0); press(4'd1); press(4'd2); press(4'd4); press(4'd5);
    press(4'd12); press(4'd3);

    // Invalid enter: empty, then "70".
    press(4'd14); press(4'd8); press(4'd13); press(4'd14); press(4'd3);

    // Function keys B, C, D.
    press(4'd7); press(4'd11); press(4'd15);

    // Randomized presses with bounce, biased toward digits and '#'.
    for (int i = 0; i < 40; i++) begin
      code = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) code = 4'd14;
      press_bouncy(code);
    end

    // Reset while HELD: no further pulses, outputs back to 0.
    begin_press(4'd5, 8'h00, 0);
    repeat (N + 5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    kp.keydown = 1'b0;
    @(negedge clk);
    chk_zero("rst_held");
    model_reset();
    rst = 1'b0;
    repeat (3 * N + 8) @(negedge clk);
    chk_zero("after_rst_held");

    // Reset mid-debounce in IDLE: press aborted, no pulse.
    kp.key     = 4'd9;
    kp.keydown = 1'b1;
    repeat (N - 1) @(negedge clk);
    rst        = 1'b1;
    kp.keydown = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3 * N + 8) @(negedge clk);
    chk_zero("rst_debounce");

    // Recovery after reset: "9" then '#' commits 00:09.
    press(4'd10); press(4'd14);

    repeat (4 * N + 10) @(negedge clk);
    chk("pending_expected_events", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Debounces and decodes the `keydown`/`key` output of the 4x4 keypad scanner into single-cycle key events. It then assembles digit keys into a 4-digit BCD MM:SS entry buffer for the countdown core. The block sits directly downstream of the scanner and upstream of the countdown timer. It delivers validated preset commits and start/pause/reset function pulses.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable `clk` samples required to accept a press or a release; legal range 1..255.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `keydown` input 1: scanner key-held flag; asynchronous to `clk`.
- `key` input 4: scanner key code, row*4+col; stable whenever `keydown`=1.
- `entry_bcd` output 16: entry buffer as four BCD digits {M10,M1,S10,S1}.
- `entry_count` output 3: number of digits entered, 0..4.
- `key_pulse` output 1: one-cycle pulse per accepted press.
- `key_code` output 4: code of the last accepted press; held between presses.
- `commit_pulse` output 1: one-cycle pulse when an entry is committed.
- `commit_bcd` output 16: last committed value; held until the next commit.
- `func_pulse` output 1: one-cycle pulse for a function key.
- `func_code` output 2: function selector; B=0 (start), C=1 (pause), D=2 (reset); held between pulses.
- `reject_pulse` output 1: one-cycle pulse when a press is ignored as illegal.

## Operation
- Key map (code -> key):
  - 0..2 -> '1','2','3'; 3 -> A.
  - 4..6 -> '4','5','6'; 7 -> B.
  - 8..10 -> '7','8','9'; 11 -> C.
  - 12 -> '*'; 13 -> '0'; 14 -> '#'; 15 -> D.
- Synchronizer: `keydown` passes through a 2-flop synchronizer to give `keydown_s`. `key` is captured on the same two stages to give `key_s`. Both are cleared by `rst`.
- FSM has three states:
  - IDLE: a counter counts consecutive cycles with `keydown_s`=1; a 0 clears it. On the DEBOUNCE_CYCLES-th consecutive 1, go to HELD and perform the action for `key_s`.
  - HELD: count consecutive cycles with `keydown_s`=0; a 1 clears the count. On the DEBOUNCE_CYCLES-th consecutive 0, go to RELEASE.
  - RELEASE: one cycle, then go to IDLE with the counter at 0.
- Each press yields exactly one action, no matter how long the key is held.
- Every accepted press sets `key_pulse`=1 and `key_code`=`key_s`.
- Digit key, `entry_count`<4: `entry_bcd`={`entry_bcd`[11:0], d} and `entry_count`+1.
- Digit key, `entry_count`=4: buffer unchanged; `reject_pulse`.
- '*' (backspace), `entry_count`>0: `entry_bcd`={4'h0, `entry_bcd`[15:4]} and `entry_count`-1.
- '*' with `entry_count`=0: no change and no reject.
- A (clear): `entry_bcd`=0, `entry_count`=0.
- '#' (enter):
  - If `entry_count`=0, or S10 (`entry_bcd`[7:4]) > 5: `reject_pulse`; buffer unchanged.
  - Otherwise: `commit_pulse`, `commit_bcd`=`entry_bcd`, then buffer and count are cleared.
  - A right-aligned entry means "45" commits as 00:45.
- B/C/D: `func_pulse` with `func_code` per the key map; buffer unchanged.

## Timing
- Reset values: all outputs 0. The FSM enters IDLE with the counter at 0.
- A key already held during reset is accepted as a new press once debounced.
- Press latency: let `keydown` be first sampled high at edge t0 and stay high. `key_pulse` and all action outputs are then registered at edge t0+2+DEBOUNCE_CYCLES and are high for exactly that one cycle.
- Bounce of the press is glitch-free: any low sample of `keydown_s` before the count completes restarts the debounce with no output.
- The earliest next accepted press comes at least 2*DEBOUNCE_CYCLES+1 cycles after the previous one.
- At most one of `commit_pulse`, `func_pulse` and `reject_pulse` is asserted per `key_pulse`. None of them is ever asserted without `key_pulse`.
- `entry_bcd`, `entry_count`, `commit_bcd` and `func_code` update on the same edge as the `key_pulse` assertion.
- `rst` mid-press (in any state) aborts immediately. No pulse is produced for that press.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset:** assert `rst` 3 cycles -> all outputs 0. Hold `keydown`=1, `key`=13 -> `key_pulse` exactly 6 cycles after the first high sample, and `entry_bcd`=0x0000, `entry_count`=1.
- **Bounce:** `keydown` toggles 1,0,1,1,0, then holds high for 20 cycles -> exactly one `key_pulse`. Release bounce 0,1,0,0, then low -> no extra pulse.
- **Entry and commit:** enter '1','2','4','5','#' -> `entry_bcd` reads 0x0001, 0x0012, 0x0124, 0x1245. Then `commit_pulse` with `commit_bcd`=0x1245, and `entry_bcd`=0, `entry_count`=0.
- **Overflow and backspace:** enter five digits '1'..'5' -> fifth press gives `reject_pulse` and `entry_bcd`=0x1234. '*' -> 0x0123, count 3. A -> 0x0000, count 0.
- **Invalid enter:** '#' with count 0 -> `reject_pulse`. Enter '7','0','#' -> `reject_pulse` (S10=7) and `entry_bcd` stays 0x0070.
- **Function keys:** B, C, D presses -> `func_pulse` with `func_code`=0,1,2 respectively, and the buffer is unchanged. `rst` asserted during HELD -> no further pulses and outputs return to 0.
